// File: rtl/pix_word_unpacker_if.sv
// Word-stream handshake carrying 256-bit grey pattern words into the pixel unpacker.
interface pix_word_unpacker_if;
    logic [255:0] in_data;
    logic         in_valid;
    logic         in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/pix_word_unpacker.sv
// Buffers 256-bit grey words in a small FIFO and emits one byte per active-video cycle.
// Optional macro PIX_UNPACK_UNDERFLOW_CNT_EN adds a saturating per-frame underflow cycle counter.
module pix_word_unpacker #(
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] FILL_GREY    = 8'h00,
    parameter bit         VS_ACTIVE_HI = 1'b1
) (
    input  logic                          pixel_clk,
    input  logic                          reset_n,
    pix_word_unpacker_if.slave            in_if,
    input  logic                          pixel_hs,
    input  logic                          pixel_vs,
    input  logic                          pixel_de,
    output logic                          frame_start,
    output logic                          out_hs,
    output logic                          out_vs,
    output logic                          out_de,
    output logic [7:0]                    out_r,
    output logic [7:0]                    out_g,
    output logic [7:0]                    out_b,
    output logic                          underflow,
`ifdef PIX_UNPACK_UNDERFLOW_CNT_EN
    output logic [15:0]                   underflow_cnt,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     LVL_FULL = FIFO_DEPTH[AW:0];

    logic [255:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [4:0]    byte_idx;
    logic          vs_act, vs_act_q, vs_edge;
    logic          empty, wr, pop, uf_cycle;
    logic [255:0]  head;
    logic [7:0]    grey;

    assign empty          = (fifo_level == '0);
    assign in_if.in_ready = (fifo_level != LVL_FULL);
    assign wr             = in_if.in_valid & in_if.in_ready;
    assign head           = mem[rptr];
    assign uf_cycle       = pixel_de & empty;

    assign vs_act  = VS_ACTIVE_HI ? pixel_vs : ~pixel_vs;
    assign vs_edge = vs_act & ~vs_act_q;

    // A frame restart throws away a partly shown head word so the new frame starts word-aligned.
    assign pop = ~empty & ((pixel_de & (byte_idx == 5'd31)) | (vs_edge & (byte_idx != 5'd0)));

    always_comb begin
        grey = 8'h00;
        if (pixel_de)
            grey = empty ? FILL_GREY : head[8*byte_idx +: 8];
    end

    always_ff @(posedge pixel_clk) begin
        if (wr)
            mem[wptr] <= in_if.in_data;
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
        end else begin
            if (wr)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({wr, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx    <= '0;
            vs_act_q    <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            out_hs      <= 1'b0;
            out_vs      <= 1'b0;
            out_de      <= 1'b0;
            out_r       <= '0;
            out_g       <= '0;
            out_b       <= '0;
        end else begin
            vs_act_q    <= vs_act;
            frame_start <= vs_edge;
            out_hs      <= pixel_hs;
            out_vs      <= pixel_vs;
            out_de      <= pixel_de;
            out_r       <= grey;
            out_g       <= grey;
            out_b       <= grey;
            if (vs_edge)
                byte_idx <= '0;
            else if (pixel_de && !empty)
                byte_idx <= byte_idx + 5'd1;
            // Clear has priority over a same-cycle set.
            if (vs_edge)
                underflow <= 1'b0;
            else if (uf_cycle)
                underflow <= 1'b1;
        end
    end

`ifdef PIX_UNPACK_UNDERFLOW_CNT_EN
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n)
            underflow_cnt <= '0;
        else if (vs_edge)
            underflow_cnt <= '0;
        else if (uf_cycle && underflow_cnt != 16'hFFFF)
            underflow_cnt <= underflow_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pix_word_unpacker.sv
// Scoreboard bench for pix_word_unpacker: a queue model predicts each output cycle.
module tb_pix_word_unpacker;
    localparam int         DEPTH = 4;
    localparam logic [7:0] FILL  = 8'h00;

    logic pixel_clk = 1'b0;
    logic reset_n;
    logic pixel_hs, pixel_vs, pixel_de;
    logic frame_start, out_hs, out_vs, out_de, underflow;
    logic [7:0] out_r, out_g, out_b;
    logic [$clog2(DEPTH):0] fifo_level;
`ifdef PIX_UNPACK_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt;
`endif

    pix_word_unpacker_if in_if ();

    pix_word_unpacker #(.FIFO_DEPTH(DEPTH), .FILL_GREY(FILL), .VS_ACTIVE_HI(1'b1)) dut (
        .pixel_clk   (pixel_clk),
        .reset_n     (reset_n),
        .in_if       (in_if.slave),
        .pixel_hs    (pixel_hs),
        .pixel_vs    (pixel_vs),
        .pixel_de    (pixel_de),
        .frame_start (frame_start),
        .out_hs      (out_hs),
        .out_vs      (out_vs),
        .out_de      (out_de),
        .out_r       (out_r),
        .out_g       (out_g),
        .out_b       (out_b),
        .underflow   (underflow),
`ifdef PIX_UNPACK_UNDERFLOW_CNT_EN
        .underflow_cnt (underflow_cnt),
`endif
        .fifo_level  (fifo_level)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct packed {
        logic       hs, vs, de, fs;
        logic [7:0] grey;
    } exp_t;

    exp_t         exp_q [$];
    logic [255:0] mq    [$];
    int           bidx;
    bit           muf, mvsq;
    int           mcnt;

    // Reference model, advanced on the same edge the DUT samples.
    always @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            exp_q.delete();
            bidx <= 0;
            muf  <= 1'b0;
            mvsq <= 1'b0;
            mcnt <= 0;
        end else begin
            automatic bit   mempty = (mq.size() == 0);
            automatic bit   mfull  = (mq.size() == DEPTH);
            automatic bit   edge_v = pixel_vs && !mvsq;
            automatic logic [255:0] h = mempty ? '0 : mq[0];
            automatic exp_t e;
            automatic bit   mpop;
            e.hs   = pixel_hs;
            e.vs   = pixel_vs;
            e.de   = pixel_de;
            e.fs   = edge_v;
            e.grey = !pixel_de ? 8'h00 : (mempty ? FILL : h[8*bidx +: 8]);
            exp_q.push_back(e);
            mpop = !mempty && ((pixel_de && bidx == 31) || (edge_v && bidx != 0));
            if (mpop) void'(mq.pop_front());
            if (in_if.in_valid && !mfull) mq.push_back(in_if.in_data);
            if (edge_v) bidx <= 0;
            else if (pixel_de && !mempty) bidx <= (bidx + 1) % 32;
            if (edge_v) muf <= 1'b0;
            else if (pixel_de && mempty) muf <= 1'b1;
            if (edge_v) mcnt <= 0;
            else if (pixel_de && mempty && mcnt < 65535) mcnt <= mcnt + 1;
            mvsq <= pixel_vs;
        end
    end

    always @(negedge pixel_clk) begin
        if (reset_n && exp_q.size() > 0) begin
            automatic exp_t e = exp_q.pop_front();
            chk("out_r", {24'h0, out_r}, {24'h0, e.grey});
            chk("out_g", {24'h0, out_g}, {24'h0, e.grey});
            chk("out_b", {24'h0, out_b}, {24'h0, e.grey});
            chk("out_ctl", {28'h0, out_hs, out_vs, out_de, frame_start}, {28'h0, e.hs, e.vs, e.de, e.fs});
            chk("underflow", {31'h0, underflow}, {31'h0, muf});
            chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
            chk("in_ready", {31'h0, in_if.in_ready}, {31'h0, (mq.size() != DEPTH)});
`ifdef PIX_UNPACK_UNDERFLOW_CNT_EN
            chk("underflow_cnt", {16'h0, underflow_cnt}, 32'(mcnt));
`endif
        end
    end

    task automatic drive(input bit v, input logic [255:0] d, input bit hs, input bit vs, input bit de);
        in_if.in_valid = v;
        in_if.in_data  = d;
        pixel_hs       = hs;
        pixel_vs       = vs;
        pixel_de       = de;
        @(negedge pixel_clk);
    endtask

    logic [255:0] w, wa, wb;

    initial begin
        reset_n = 1'b0;
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        pixel_hs = 1'b0; pixel_vs = 1'b0; pixel_de = 1'b0;
        repeat (3) @(negedge pixel_clk);
        chk("rst_outs", {16'h0, out_r, out_g}, 32'h0);
        chk("rst_flags", {26'h0, out_b[0], frame_start, out_hs, out_vs, out_de, underflow}, 32'h0);
        chk("rst_level", 32'(fifo_level), 32'h0);
        reset_n = 1'b1;
        drive(0, '0, 0, 0, 0);
        chk("rel_ready", {31'h0, in_if.in_ready}, 32'h1);

        // Four ramp words, then 40 active pixels.
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 32; j++) w[8*j +: 8] = 8'(k*32 + j);
            drive(1, w, 0, 0, 0);
        end
        chk("full_ready", {31'h0, in_if.in_ready}, 32'h0);
        drive(0, '0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            drive(0, '0, 0, 0, 1);
            if (i == 0) chk("first_pix", {24'h0, out_r}, 32'h00);
            if (i == 32) chk("word1_pix", {24'h0, out_r}, 32'h20);
        end
        chk("lvl_after40", 32'(fifo_level), 32'd3);

        // Drain and run dry.
        for (int i = 0; i < 98; i++) drive(0, '0, 0, 0, 1);
        chk("uf_set", {31'h0, underflow}, 32'h1);
        chk("uf_fill", {24'h0, out_g}, {24'h0, FILL});
        drive(0, '0, 0, 0, 0);
        drive(0, '0, 0, 1, 0);
        chk("fs_pulse", {31'h0, frame_start}, 32'h1);
        chk("uf_clr", {31'h0, underflow}, 32'h0);
        drive(0, '0, 0, 1, 0);
        chk("fs_once", {31'h0, frame_start}, 32'h0);
        drive(0, '0, 0, 0, 0);

        // Partial head discarded at vs edge.
        wa = {8{$urandom()}};
        wb = {8{$urandom()}};
        drive(1, wa, 0, 0, 0);
        drive(1, wb, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, '0, 0, 0, 1);
        drive(0, '0, 0, 1, 0);
        chk("discard_lvl", 32'(fifo_level), 32'd1);
        drive(0, '0, 0, 0, 0);
        drive(0, '0, 0, 0, 1);
        chk("discard_pix", {24'h0, out_r}, {24'h0, wb[7:0]});

`ifdef PIX_UNPACK_UNDERFLOW_CNT_EN
        for (int i = 0; i < 31; i++) drive(0, '0, 0, 0, 1);
        drive(0, '0, 0, 1, 0);
        drive(0, '0, 0, 0, 0);
        for (int i = 0; i < 100; i++) drive(0, '0, 0, 0, 1);
        chk("ucnt_100", {16'h0, underflow_cnt}, 32'd100);
        drive(0, '0, 0, 1, 0);
        chk("ucnt_clr", {16'h0, underflow_cnt}, 32'd0);
`endif

        // Small frame: 40-pixel lines so byte_idx carries across lines.
        drive(0, '0, 0, 0, 0);
        drive(0, '0, 0, 1, 0);
        for (int i = 0; i < 6; i++) drive($urandom_range(0, 1) == 1, {8{$urandom()}}, 0, 1, 0);
        for (int ln = 0; ln < 6; ln++) begin
            for (int i = 0; i < 4; i++) drive(1, {8{$urandom()}}, 1, 0, 0);
            for (int i = 0; i < 8; i++) drive(1, {8{$urandom()}}, 0, 0, 0);
            for (int i = 0; i < 40; i++) drive($urandom_range(0, 3) != 0, {8{$urandom()}}, 0, 0, 1);
        end

        // Reset mid-line, then resume with an empty FIFO.
        drive(1, {8{$urandom()}}, 0, 0, 1);
        @(posedge pixel_clk);
        #2 reset_n = 1'b0;
        @(negedge pixel_clk);
        chk("mid_rst_out", {23'h0, out_r, out_de}, 32'h0);
        chk("mid_rst_lvl", 32'(fifo_level), 32'h0);
        in_if.in_valid = 1'b0;
        pixel_de = 1'b0;
        @(negedge pixel_clk);
        reset_n = 1'b1;
        drive(0, '0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, '0, 0, 0, 1);
        chk("mid_rst_uf", {31'h0, underflow}, 32'h1);
        drive(0, '0, 0, 1, 0);
        chk("mid_rst_uf_clr", {31'h0, underflow}, 32'h0);
        drive(0, '0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
